noc_cpu_interface: RTL and testbench

- Clocked network interface between a CPU core and its mesh Router node.
- TX side: queues CPU send requests (32-bit word plus destination x/y) and drives them onto the router's event-triggered from_cpu/in_x_cpu/in_y_cpu inputs, with one word in flight and a guaranteed gap between words.
- RX side: synchronizes the router's asynchronous set_fi delivery pulse, captures to_cpu into a receive FIFO, and presents the words to the CPU through a valid/ready handshake with a level interrupt.

---
 rtl/noc_cpu_interface.sv | 158 +++++++++++++++
 tb/tb_noc_cpu_interface.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_cpu_interface.sv
// CPU <-> mesh router network interface: queued, rate-limited TX onto the router's
// event-triggered inputs; synchronized RX capture into a FIFO with valid/ready and irq.
`timescale 1ns/1ps
module noc_cpu_interface #(
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4,
   parameter int TX_GAP   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_tx_valid,
   output logic        cpu_tx_ready,
   input  logic [31:0] cpu_tx_data,
   input  logic [15:0] cpu_tx_x,
   input  logic [15:0] cpu_tx_y,
   output logic [31:0] from_cpu,
   output logic [15:0] in_x_cpu,
   output logic [15:0] in_y_cpu,
   input  logic [31:0] to_cpu,
   input  logic        set_fi,
   output logic        cpu_rx_valid,
   input  logic        cpu_rx_ready,
   output logic [31:0] cpu_rx_data,
   output logic        irq,
   output logic        rx_overflow,
   output logic        tx_dup,
   input  logic        clr_status
);

   localparam int TXA = $clog2(TX_DEPTH);
   localparam int RXA = $clog2(RX_DEPTH);
   localparam int GW  = $clog2(TX_GAP);

   typedef struct packed {
      logic [15:0] y;
      logic [15:0] x;
      logic [31:0] data;
   } tx_req_t;

   typedef enum logic {IDLE, GAP} tx_state_t;

   // ---------------- TX FIFO (pointers carry one extra wrap bit) ----------------
   tx_req_t          tx_mem [TX_DEPTH];
   logic [TXA:0]     tx_wr, tx_rd;
   logic             tx_full, tx_empty, tx_push, tx_pop;
   tx_req_t          tx_head;
   tx_state_t        tx_state;
   logic [GW-1:0]    gap_cnt;

   assign tx_empty     = (tx_wr == tx_rd);
   assign tx_full      = (tx_wr[TXA] != tx_rd[TXA]) && (tx_wr[TXA-1:0] == tx_rd[TXA-1:0]);
   assign cpu_tx_ready = !tx_full;
   assign tx_push      = cpu_tx_valid && !tx_full;
   assign tx_pop       = (tx_state == IDLE) && !tx_empty;
   assign tx_head      = tx_mem[tx_rd[TXA-1:0]];

   always_ff @(posedge clk) begin
      if (tx_push)
         tx_mem[tx_wr[TXA-1:0]] <= '{y: cpu_tx_y, x: cpu_tx_x, data: cpu_tx_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wr <= '0;
         tx_rd <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + 1'b1;
         if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      end
   end

   // The router only reacts to a change on from_cpu, so an unchanged payload is
   // unsendable and gets dropped; otherwise hold off TX_GAP cycles between updates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= IDLE;
         gap_cnt  <= '0;
         from_cpu <= '0;
         in_x_cpu <= '0;
         in_y_cpu <= '0;
         tx_dup   <= 1'b0;
      end else begin
         tx_dup <= 1'b0;
         case (tx_state)
            IDLE: begin
               if (!tx_empty) begin
                  if (tx_head.data != from_cpu) begin
                     from_cpu <= tx_head.data;
                     in_x_cpu <= tx_head.x;
                     in_y_cpu <= tx_head.y;
                     gap_cnt  <= GW'(TX_GAP - 1);
                     tx_state <= GAP;
                  end else begin
                     tx_dup <= 1'b1;
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt - GW'(1);
               if (gap_cnt == GW'(1)) tx_state <= IDLE;
            end
         endcase
      end
   end

   // ---------------- RX capture ----------------
   logic        s1, s2, cap, hold_vld;
   logic [31:0] hold_data;

   assign cap = s1 & ~s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         hold_vld  <= 1'b0;
         hold_data <= '0;
      end else begin
         s1       <= set_fi;
         s2       <= s1;
         hold_vld <= cap;
         if (cap) hold_data <= to_cpu;
      end
   end

   // ---------------- RX FIFO ----------------
   logic [31:0]  rx_mem [RX_DEPTH];
   logic [RXA:0] rx_wr, rx_rd;
   logic         rx_full, rx_empty, rx_push, rx_pop, rx_drop;

   assign rx_empty     = (rx_wr == rx_rd);
   assign rx_full      = (rx_wr[RXA] != rx_rd[RXA]) && (rx_wr[RXA-1:0] == rx_rd[RXA-1:0]);
   assign cpu_rx_valid = !rx_empty;
   assign irq          = cpu_rx_valid;
   assign cpu_rx_data  = rx_mem[rx_rd[RXA-1:0]];
   assign rx_pop       = cpu_rx_valid && cpu_rx_ready;
   // A pop on the same edge frees the slot, so a full FIFO still accepts then.
   assign rx_push      = hold_vld && (!rx_full || rx_pop);
   assign rx_drop      = hold_vld && rx_full && !rx_pop;

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr[RXA-1:0]] <= hold_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wr       <= '0;
         rx_rd       <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (rx_push) rx_wr <= rx_wr + 1'b1;
         if (rx_pop)  rx_rd <= rx_rd + 1'b1;
         if (rx_drop)         rx_overflow <= 1'b1;
         else if (clr_status) rx_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_noc_cpu_interface.sv
// Directed bench for noc_cpu_interface with TX/RX scoreboards and immediate assertions.
`timescale 1ns/1ps
module tb_noc_cpu_interface;
   localparam int TX_DEPTH = 4, RX_DEPTH = 4, TX_GAP = 8;

   logic        clk = 1'b0, rst = 1'b1;
   logic        cpu_tx_valid = 1'b0, cpu_tx_ready;
   logic [31:0] cpu_tx_data = '0;
   logic [15:0] cpu_tx_x = '0, cpu_tx_y = '0;
   logic [31:0] from_cpu;
   logic [15:0] in_x_cpu, in_y_cpu;
   logic [31:0] to_cpu = '0;
   logic        set_fi = 1'b0;
   logic        cpu_rx_valid, cpu_rx_ready = 1'b0;
   logic [31:0] cpu_rx_data;
   logic        irq, rx_overflow, tx_dup;
   logic        clr_status = 1'b0;

   noc_cpu_interface #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .TX_GAP(TX_GAP)) dut (
      .clk(clk), .rst(rst),
      .cpu_tx_valid(cpu_tx_valid), .cpu_tx_ready(cpu_tx_ready),
      .cpu_tx_data(cpu_tx_data), .cpu_tx_x(cpu_tx_x), .cpu_tx_y(cpu_tx_y),
      .from_cpu(from_cpu), .in_x_cpu(in_x_cpu), .in_y_cpu(in_y_cpu),
      .to_cpu(to_cpu), .set_fi(set_fi),
      .cpu_rx_valid(cpu_rx_valid), .cpu_rx_ready(cpu_rx_ready), .cpu_rx_data(cpu_rx_data),
      .irq(irq), .rx_overflow(rx_overflow), .tx_dup(tx_dup), .clr_status(clr_status)
   );

   always #1 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] d;
      logic [15:0] x;
      logic [15:0] y;
   } tx_ev_t;

   tx_ev_t      tx_exp[$];
   tx_ev_t      tx_obs[$];
   logic [31:0] rx_exp[$];
   int          cyc = 0;
   int          dup_cnt = 0;
   logic [31:0] prev_from = '0;
   int          n_chk = 0, n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every change on from_cpu with the posedge index that produced it.
   always @(negedge clk) begin
      if (from_cpu !== prev_from) tx_obs.push_back('{cyc, from_cpu, in_x_cpu, in_y_cpu});
      prev_from <= from_cpu;
      if (tx_dup) dup_cnt <= dup_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required $finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_tx(input logic [31:0] d, input logic [15:0] x, input logic [15:0] y);
      cpu_tx_valid = 1'b1;
      cpu_tx_data  = d;
      cpu_tx_x     = x;
      cpu_tx_y     = y;
      @(negedge clk);
   endtask

   task automatic drain_tx(input string tag);
      tx_ev_t e, o;
      check({tag, "_n"}, 64'(tx_obs.size()), 64'(tx_exp.size()));
      while (tx_exp.size() > 0 && tx_obs.size() > 0) begin
         e = tx_exp.pop_front();
         o = tx_obs.pop_front();
         check({tag, "_cyc"}, 64'(o.cyc), 64'(e.cyc));
         check({tag, "_data"}, 64'(o.d), 64'(e.d));
         check({tag, "_xy"}, 64'({o.y, o.x}), 64'({e.y, e.x}));
      end
      tx_exp.delete();
      tx_obs.delete();
   endtask

   // set_fi held 6 time units (3 clk periods); next delivery at least 4 cycles later.
   task automatic deliver(input logic [31:0] d);
      to_cpu = d;
      set_fi = 1'b1;
      repeat (3) @(negedge clk);
      set_fi = 1'b0;
      @(negedge clk);
   endtask

   task automatic rx_pop(input string tag);
      logic [31:0] e;
      e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 32'hxxxx_xxxx;
      check({tag, "_vld"}, 64'(cpu_rx_valid), 64'(1));
      check(tag, 64'(cpu_rx_data), 64'(e));
      cpu_rx_ready = 1'b1;
      @(negedge clk);
      cpu_rx_ready = 1'b0;
   endtask

   int p;
   initial begin
      repeat (2) @(negedge clk);
      check("rst_from", 64'(from_cpu), 64'(0));
      check("rst_xy", 64'({in_y_cpu, in_x_cpu}), 64'(0));
      check("rst_txrdy", 64'(cpu_tx_ready), 64'(1));
      check("rst_rxvld", 64'({cpu_rx_valid, irq}), 64'(0));
      check("rst_flags", 64'({rx_overflow, tx_dup}), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Zero word right after reset matches from_cpu and must be discarded
      drive_tx(32'h0, 16'd7, 16'd7);
      cpu_tx_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("zero_dup", 64'(dup_cnt), 64'(1));
      check("zero_from", 64'(from_cpu), 64'(0));
      check("zero_x", 64'(in_x_cpu), 64'(0));
      check("zero_nochg", 64'(tx_obs.size()), 64'(0));

      // Single send: visible one cycle after the push edge
      p = cyc + 1;
      drive_tx(32'h1234_5678, 16'd2, 16'd1);
      cpu_tx_valid = 1'b0;
      tx_exp.push_back('{p + 1, 32'h1234_5678, 16'd2, 16'd1});
      @(negedge clk);
      check("t1_from", 64'(from_cpu), 64'h1234_5678);
      check("t1_x", 64'(in_x_cpu), 64'(2));
      check("t1_y", 64'(in_y_cpu), 64'(1));
      check("t1_rdy", 64'(cpu_tx_ready), 64'(1));
      repeat (12) @(negedge clk);
      drain_tx("t1");

      // Three back-to-back pushes spaced by TX_GAP
      p = cyc + 1;
      drive_tx(32'hA, 16'd3, 16'd4);
      drive_tx(32'hB, 16'd5, 16'd6);
      drive_tx(32'hC, 16'd7, 16'd8);
      cpu_tx_valid = 1'b0;
      tx_exp.push_back('{p + 1,  32'hA, 16'd3, 16'd4});
      tx_exp.push_back('{p + 9,  32'hB, 16'd5, 16'd6});
      tx_exp.push_back('{p + 17, 32'hC, 16'd7, 16'd8});
      repeat (24) @(negedge clk);
      drain_tx("t2");
      check("t2_nodup", 64'(dup_cnt), 64'(1));

      // Repeated payload: second copy dropped once it reaches the head
      p = cyc + 1;
      drive_tx(32'h5, 16'd1, 16'd1);
      drive_tx(32'h5, 16'd9, 16'd9);
      cpu_tx_valid = 1'b0;
      tx_exp.push_back('{p + 1, 32'h5, 16'd1, 16'd1});
      repeat (16) @(negedge clk);
      drain_tx("t3");
      check("t3_dup", 64'(dup_cnt), 64'(2));
      check("t3_from", 64'(from_cpu), 64'h5);
      check("t3_x", 64'(in_x_cpu), 64'(1));

      // Single delivery: valid on the third edge after set_fi rises
      to_cpu = 32'hDEAD_BEEF;
      set_fi = 1'b1;
      rx_exp.push_back(32'hDEAD_BEEF);
      repeat (2) @(negedge clk);
      check("rx_lat2", 64'(cpu_rx_valid), 64'(0));
      @(negedge clk);
      set_fi = 1'b0;
      check("rx_lat3", 64'(cpu_rx_valid), 64'(1));
      check("rx_irq", 64'(irq), 64'(1));
      rx_pop("rx_one");
      check("rx_empty", 64'({cpu_rx_valid, irq}), 64'(0));
      repeat (2) @(negedge clk);

      // Overfill: five deliveries into a 4-deep FIFO
      for (int i = 1; i <= 5; i++) begin
         deliver(32'(i));
         if (i <= RX_DEPTH) rx_exp.push_back(32'(i));
         if (i == RX_DEPTH) check("rx_nofl", 64'(rx_overflow), 64'(0));
      end
      check("rx_ovf", 64'(rx_overflow), 64'(1));
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      check("rx_clr", 64'(rx_overflow), 64'(0));

      // Delivery landing on a full FIFO in the same edge as a pop is kept
      to_cpu = 32'h6;
      set_fi = 1'b1;
      repeat (2) @(negedge clk);
      check("rx_full_head", 64'(cpu_rx_data), 64'(rx_exp.pop_front()));
      cpu_rx_ready = 1'b1;
      rx_exp.push_back(32'h6);
      @(negedge clk);
      cpu_rx_ready = 1'b0;
      set_fi = 1'b0;
      check("rx_pop_push_ovf", 64'(rx_overflow), 64'(0));
      @(negedge clk);
      for (int i = 0; i < RX_DEPTH; i++) rx_pop("rx_drain");
      check("rx_drained", 64'(cpu_rx_valid), 64'(0));

      // Fill the TX FIFO, try one more push, then reset in the middle of GAP
      p = cyc + 1;
      for (int i = 0; i <= TX_DEPTH; i++) drive_tx(32'h100 + 32'(i), 16'(i), 16'(i));
      check("tx_full_rdy", 64'(cpu_tx_ready), 64'(0));
      check("tx_full_from", 64'(from_cpu), 64'h100);
      drive_tx(32'h1FF, 16'd15, 16'd15);
      cpu_tx_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("mrst_from", 64'(from_cpu), 64'(0));
      check("mrst_xy", 64'({in_y_cpu, in_x_cpu}), 64'(0));
      check("mrst_rdy", 64'(cpu_tx_ready), 64'(1));
      check("mrst_rx", 64'({cpu_rx_valid, irq, rx_overflow, tx_dup}), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      tx_obs.delete();
      tx_exp.delete();
      repeat (30) @(negedge clk);
      check("mrst_quiet", 64'(tx_obs.size()), 64'(0));
      check("mrst_from2", 64'(from_cpu), 64'(0));
      check("mrst_nodup", 64'(dup_cnt), 64'(2));

      // FSM back in IDLE: a fresh push goes out on the next edge
      p = cyc + 1;
      drive_tx(32'h77, 16'd4, 16'd5);
      cpu_tx_valid = 1'b0;
      tx_exp.push_back('{p + 1, 32'h77, 16'd4, 16'd5});
      repeat (10) @(negedge clk);
      drain_tx("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
